// File: rtl/sram_axi_bridge.sv
// Bridges the core's inst/data SRAM-like ports onto one AXI3 master; single-beat transfers only.
// Read: addrok, then AR, then R, with dataok one cycle after the R handshake. Data port is in-order with one access in flight.
module sram_axi_bridge #(
    parameter logic [3:0] ID_INST = 4'd0,
    parameter logic [3:0] ID_DATA = 4'd1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addrok,
    output logic        inst_sram_dataok,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addrok,
    output logic        data_sram_dataok,
    output logic [31:0] data_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_AW, W_B} w_state_t;

    r_state_t    r_state, r_next;
    w_state_t    w_state, w_next;
    logic        data_busy, rd_src;
    logic        aw_done, w_done;
    logic [3:0]  ar_id;
    logic [31:0] ar_addr, aw_addr, w_data;
    logic [1:0]  ar_size, aw_size;
    logic [3:0]  w_strb;
    logic        data_rd_acc, data_wr_acc, inst_rd_acc, data_done;

    // Routing relies on rd_src rather than ids, and responses are assumed OKAY.
    logic unused_inputs;
    assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rid, rresp, rlast, bid, bresp};

    always_comb begin
        data_rd_acc = data_sram_req & ~data_sram_wr & (r_state == R_IDLE) & ~data_busy;
        data_wr_acc = data_sram_req &  data_sram_wr & (w_state == W_IDLE) & ~data_busy;
        inst_rd_acc = inst_sram_req & (r_state == R_IDLE) & ~data_rd_acc;
        data_done   = ((r_state == R_R) & rvalid & rd_src) | ((w_state == W_B) & bvalid);
    end

    assign inst_sram_addrok = inst_rd_acc;
    assign data_sram_addrok = data_rd_acc | data_wr_acc;

    assign arid    = ar_id;
    assign araddr  = ar_addr;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, ar_size};
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign awid    = ID_DATA;
    assign awaddr  = aw_addr;
    assign awlen   = 8'd0;
    assign awsize  = {1'b0, aw_size};
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign wid     = ID_DATA;
    assign wdata   = w_data;
    assign wstrb   = w_strb;
    assign wlast   = 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= R_IDLE;
            w_state <= W_IDLE;
        end else begin
            r_state <= r_next;
            w_state <= w_next;
        end
    end

    always_comb begin
        r_next  = r_state;
        arvalid = 1'b0;
        rready  = 1'b0;
        case (r_state)
            R_IDLE: if (data_rd_acc | inst_rd_acc) r_next = R_AR;
            R_AR: begin
                arvalid = 1'b1;
                if (arready) r_next = R_R;
            end
            R_R: begin
                rready = 1'b1;
                if (rvalid) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // AW and W complete independently; the done flags remember whichever finished first.
    always_comb begin
        w_next  = w_state;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        case (w_state)
            W_IDLE: if (data_wr_acc) w_next = W_AW;
            W_AW: begin
                awvalid = ~aw_done;
                wvalid  = ~w_done;
                if ((aw_done | awready) & (w_done | wready)) w_next = W_B;
            end
            W_B: begin
                bready = 1'b1;
                if (bvalid) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ar_id            <= 4'd0;
            ar_addr          <= 32'd0;
            ar_size          <= 2'd0;
            rd_src           <= 1'b0;
            aw_addr          <= 32'd0;
            aw_size          <= 2'd0;
            w_data           <= 32'd0;
            w_strb           <= 4'd0;
            aw_done          <= 1'b0;
            w_done           <= 1'b0;
            data_busy        <= 1'b0;
            inst_sram_dataok <= 1'b0;
            data_sram_dataok <= 1'b0;
            inst_sram_rdata  <= 32'd0;
            data_sram_rdata  <= 32'd0;
        end else begin
            if (data_rd_acc) begin
                ar_id   <= ID_DATA;
                ar_addr <= data_sram_addr;
                ar_size <= data_sram_size;
                rd_src  <= 1'b1;
            end else if (inst_rd_acc) begin
                ar_id   <= ID_INST;
                ar_addr <= inst_sram_addr;
                ar_size <= inst_sram_size;
                rd_src  <= 1'b0;
            end
            if (data_wr_acc) begin
                aw_addr <= data_sram_addr;
                aw_size <= data_sram_size;
                w_data  <= data_sram_wdata;
                w_strb  <= data_sram_wstrb;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else if (w_state == W_AW) begin
                if (awvalid & awready) aw_done <= 1'b1;
                if (wvalid & wready)   w_done  <= 1'b1;
            end
            inst_sram_dataok <= 1'b0;
            data_sram_dataok <= 1'b0;
            if ((r_state == R_R) & rvalid) begin
                if (rd_src) begin
                    data_sram_rdata  <= rdata;
                    data_sram_dataok <= 1'b1;
                end else begin
                    inst_sram_rdata  <= rdata;
                    inst_sram_dataok <= 1'b1;
                end
            end
            if ((w_state == W_B) & bvalid) data_sram_dataok <= 1'b1;
            if (data_sram_addrok)  data_busy <= 1'b1;
            else if (data_done)    data_busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Scenario bench for sram_axi_bridge: the bench plays the AXI slave backed by a sparse memory model.
module tb_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_sram_req, inst_sram_wr, inst_sram_addrok, inst_sram_dataok;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
    logic [3:0]  inst_sram_wstrb;
    logic        data_sram_req, data_sram_wr, data_sram_addrok, data_sram_dataok;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
    logic [3:0]  data_sram_wstrb;
    logic [3:0]  arid, awid, wid, rid, bid, arcache, awcache, wstrb;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int checks = 0;
    int failures = 0;
    logic [31:0] mem [logic [31:0]];

    always #5 clk = ~clk;

    sram_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addrok(inst_sram_addrok), .inst_sram_dataok(inst_sram_dataok), .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
        .data_sram_addr(data_sram_addr), .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
        .data_sram_addrok(data_sram_addrok), .data_sram_dataok(data_sram_dataok), .data_sram_rdata(data_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    // Slave side of one read: waits for AR, optionally stalls arready, then returns mem[araddr].
    // Returns one cycle after the R handshake, i.e. when dataok should be visible.
    task automatic serve_read(input int ar_delay, output logic [3:0] id, output logic [31:0] addr,
                              output logic [2:0] size, output bit ok);
        int n;
        ok = 1'b1; id = 4'hx; addr = 32'hx; size = 3'hx;
        n = 0;
        while (!arvalid && n < 20) begin tick(); n++; end
        if (!arvalid) begin ok = 1'b0; return; end
        id = arid; addr = araddr; size = arsize;
        repeat (ar_delay) tick();
        arready = 1'b1; tick(); arready = 1'b0;
        n = 0;
        while (!rready && n < 20) begin tick(); n++; end
        if (!rready) begin ok = 1'b0; return; end
        rvalid = 1'b1; rid = id; rdata = mem_rd(addr);
        tick();
        rvalid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0) begin failures++; $display("FAIL reset_valids got=%b exp=00000", {arvalid, rready, awvalid, wvalid, bready}); end
        checks++; if ({inst_sram_addrok, inst_sram_dataok, data_sram_addrok, data_sram_dataok} !== 4'b0) begin failures++; $display("FAIL reset_ok got=%b exp=0000", {inst_sram_addrok, inst_sram_dataok, data_sram_addrok, data_sram_dataok}); end
        checks++; if ({inst_sram_rdata, data_sram_rdata} !== 64'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", {inst_sram_rdata, data_sram_rdata}); end
        checks++; if ({arlen, awlen, arburst, awburst, wlast, awid, wid} !== {16'd0, 2'b01, 2'b01, 1'b1, 4'd1, 4'd1}) begin failures++; $display("FAIL const_fields got=%h", {arlen, awlen, arburst, awburst, wlast, awid, wid}); end
        checks++; if ({arlock, awlock, arcache, awcache, arprot, awprot} !== 18'd0) begin failures++; $display("FAIL const_attr got=%h exp=0", {arlock, awlock, arcache, awcache, arprot, awprot}); end
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        tick();
        checks++; if ({arvalid, awvalid, wvalid} !== 3'b0) begin failures++; $display("FAIL post_reset_idle got=%b exp=000", {arvalid, awvalid, wvalid}); end
    endtask

    task automatic test_inst_read();
        inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC00000; inst_sram_size = 2'd2; #1;
        checks++; if (inst_sram_addrok !== 1'b1) begin failures++; $display("FAIL inst_addrok got=%b exp=1", inst_sram_addrok); end
        tick(); inst_sram_req = 1'b0;
        checks++; if ({arvalid, arid, araddr, arsize} !== {1'b1, 4'd0, 32'hBFC00000, 3'b010}) begin failures++; $display("FAIL inst_ar got=%h exp=%h", {arvalid, arid, araddr, arsize}, {1'b1, 4'd0, 32'hBFC00000, 3'b010}); end
        arready = 1'b1; tick(); arready = 1'b0;
        checks++; if ({arvalid, rready} !== 2'b01) begin failures++; $display("FAIL inst_rphase got=%b exp=01", {arvalid, rready}); end
        rvalid = 1'b1; rid = 4'd0; rdata = 32'h3C1DBFC0; #1;
        checks++; if (inst_sram_dataok !== 1'b0) begin failures++; $display("FAIL inst_dataok_early got=%b exp=0", inst_sram_dataok); end
        tick(); rvalid = 1'b0;
        checks++; if ({inst_sram_dataok, data_sram_dataok, inst_sram_rdata} !== {2'b10, 32'h3C1DBFC0}) begin failures++; $display("FAIL inst_resp got=%h exp=%h", {inst_sram_dataok, data_sram_dataok, inst_sram_rdata}, {2'b10, 32'h3C1DBFC0}); end
        tick();
        checks++; if ({inst_sram_dataok, inst_sram_rdata} !== {1'b0, 32'h3C1DBFC0}) begin failures++; $display("FAIL inst_pulse_hold got=%h exp=%h", {inst_sram_dataok, inst_sram_rdata}, {1'b0, 32'h3C1DBFC0}); end
    endtask

    task automatic test_read_priority();
        logic [31:0] ia, da, a; logic [3:0] id; logic [2:0] sz; bit ok;
        ia = $urandom & ~32'h3; da = $urandom & ~32'h3;
        inst_sram_req = 1'b1; inst_sram_addr = ia; inst_sram_size = 2'd2;
        data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = da; data_sram_size = 2'd2; #1;
        checks++; if ({data_sram_addrok, inst_sram_addrok} !== 2'b10) begin failures++; $display("FAIL prio_addrok got=%b exp=10", {data_sram_addrok, inst_sram_addrok}); end
        tick(); data_sram_req = 1'b0; #1;
        checks++; if (inst_sram_addrok !== 1'b0) begin failures++; $display("FAIL prio_inst_blocked got=%b exp=0", inst_sram_addrok); end
        serve_read(0, id, a, sz, ok);
        checks++; if ({ok, id, a} !== {1'b1, 4'd1, da}) begin failures++; $display("FAIL prio_data_ar got=%h exp=%h", {ok, id, a}, {1'b1, 4'd1, da}); end
        checks++; if ({data_sram_dataok, inst_sram_dataok, data_sram_rdata} !== {2'b10, mem_rd(da)}) begin failures++; $display("FAIL prio_data_resp got=%h exp=%h", {data_sram_dataok, inst_sram_dataok, data_sram_rdata}, {2'b10, mem_rd(da)}); end
        checks++; if (inst_sram_addrok !== 1'b1) begin failures++; $display("FAIL prio_inst_retry got=%b exp=1", inst_sram_addrok); end
        tick(); inst_sram_req = 1'b0;
        serve_read(0, id, a, sz, ok);
        checks++; if ({ok, id, a, inst_sram_dataok, inst_sram_rdata} !== {1'b1, 4'd0, ia, 1'b1, mem_rd(ia)}) begin failures++; $display("FAIL prio_inst_resp got=%h exp=%h", {ok, id, a, inst_sram_dataok, inst_sram_rdata}, {1'b1, 4'd0, ia, 1'b1, mem_rd(ia)}); end
    endtask

    task automatic test_write();
        tick();
        data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h80001000;
        data_sram_size = 2'd1; data_sram_wstrb = 4'b0011; data_sram_wdata = 32'h1234ABCD; #1;
        checks++; if (data_sram_addrok !== 1'b1) begin failures++; $display("FAIL wr_addrok got=%b exp=1", data_sram_addrok); end
        tick(); data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_wdata = 32'h0;
        checks++; if ({awvalid, wvalid, awid, wid, awaddr, awsize, wdata, wstrb, wlast} !== {2'b11, 4'd1, 4'd1, 32'h80001000, 3'b001, 32'h1234ABCD, 4'b0011, 1'b1}) begin failures++; $display("FAIL wr_aw_w got=%h", {awvalid, wvalid, awid, wid, awaddr, awsize, wdata, wstrb, wlast}); end
        wready = 1'b1; tick(); wready = 1'b0;
        checks++; if ({awvalid, wvalid, bready} !== 3'b100) begin failures++; $display("FAIL wr_w_first got=%b exp=100", {awvalid, wvalid, bready}); end
        tick();
        checks++; if ({awvalid, wvalid, bready} !== 3'b100) begin failures++; $display("FAIL wr_aw_wait got=%b exp=100", {awvalid, wvalid, bready}); end
        awready = 1'b1; tick(); awready = 1'b0;
        checks++; if ({awvalid, wvalid, bready, data_sram_dataok} !== 4'b0010) begin failures++; $display("FAIL wr_bphase got=%b exp=0010", {awvalid, wvalid, bready, data_sram_dataok}); end
        bvalid = 1'b1; bid = 4'd1; tick(); bvalid = 1'b0;
        checks++; if ({data_sram_dataok, bready} !== 2'b10) begin failures++; $display("FAIL wr_dataok got=%b exp=10", {data_sram_dataok, bready}); end
        tick();
        checks++; if (data_sram_dataok !== 1'b0) begin failures++; $display("FAIL wr_dataok_pulse got=%b exp=0", data_sram_dataok); end
    endtask

    task automatic test_write_blocks_read();
        logic [31:0] ia, dra, a; logic [3:0] id; logic [2:0] sz; bit ok; int n;
        ia = $urandom & ~32'h3; dra = $urandom & ~32'h3;
        data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = $urandom; data_sram_size = 2'd2; #1;
        checks++; if (data_sram_addrok !== 1'b1) begin failures++; $display("FAIL wb_wr_addrok got=%b exp=1", data_sram_addrok); end
        tick();
        data_sram_wr = 1'b0; data_sram_addr = dra;
        inst_sram_req = 1'b1; inst_sram_addr = ia; inst_sram_size = 2'd2; #1;
        checks++; if ({data_sram_addrok, inst_sram_addrok} !== 2'b01) begin failures++; $display("FAIL wb_addrok got=%b exp=01", {data_sram_addrok, inst_sram_addrok}); end
        tick(); inst_sram_req = 1'b0;
        serve_read($urandom_range(0, 2), id, a, sz, ok);
        checks++; if ({ok, id, a, inst_sram_dataok, inst_sram_rdata} !== {1'b1, 4'd0, ia, 1'b1, mem_rd(ia)}) begin failures++; $display("FAIL wb_inst_resp got=%h exp=%h", {ok, id, a, inst_sram_dataok, inst_sram_rdata}, {1'b1, 4'd0, ia, 1'b1, mem_rd(ia)}); end
        checks++; if ({data_sram_addrok, awvalid, wvalid} !== 3'b011) begin failures++; $display("FAIL wb_still_blocked got=%b exp=011", {data_sram_addrok, awvalid, wvalid}); end
        awready = 1'b1; wready = 1'b1; tick(); awready = 1'b0; wready = 1'b0;
        checks++; if ({data_sram_addrok, bready} !== 2'b01) begin failures++; $display("FAIL wb_bphase got=%b exp=01", {data_sram_addrok, bready}); end
        bvalid = 1'b1; tick(); bvalid = 1'b0;
        checks++; if (data_sram_dataok !== 1'b1) begin failures++; $display("FAIL wb_wr_dataok got=%b exp=1", data_sram_dataok); end
        n = 0;
        while (!data_sram_addrok && n < 4) begin tick(); n++; end
        checks++; if (data_sram_addrok !== 1'b1) begin failures++; $display("FAIL wb_rd_accept got=%b exp=1", data_sram_addrok); end
        tick(); data_sram_req = 1'b0;
        serve_read(0, id, a, sz, ok);
        checks++; if ({ok, id, a, data_sram_dataok, data_sram_rdata} !== {1'b1, 4'd1, dra, 1'b1, mem_rd(dra)}) begin failures++; $display("FAIL wb_rd_resp got=%h exp=%h", {ok, id, a, data_sram_dataok, data_sram_rdata}, {1'b1, 4'd1, dra, 1'b1, mem_rd(dra)}); end
    endtask

    task automatic test_ar_stall();
        logic [31:0] da, a; logic [1:0] s; logic [3:0] id; logic [2:0] sz; bit ok;
        da = $urandom; s = 2'($urandom_range(0, 2));
        tick();
        data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = da; data_sram_size = s; #1;
        checks++; if (data_sram_addrok !== 1'b1) begin failures++; $display("FAIL stall_addrok got=%b exp=1", data_sram_addrok); end
        tick(); data_sram_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            data_sram_addr = $urandom; data_sram_size = 2'($urandom); #1;
            checks++; if ({arvalid, arid, araddr, arsize} !== {1'b1, 4'd1, da, 1'b0, s}) begin failures++; $display("FAIL stall_ar_stable cyc=%0d got=%h exp=%h", i, {arvalid, arid, araddr, arsize}, {1'b1, 4'd1, da, 1'b0, s}); end
            tick();
        end
        serve_read(0, id, a, sz, ok);
        checks++; if ({ok, data_sram_dataok, data_sram_rdata} !== {2'b11, mem_rd(da)}) begin failures++; $display("FAIL stall_resp got=%h exp=%h", {ok, data_sram_dataok, data_sram_rdata}, {2'b11, mem_rd(da)}); end
    endtask

    task automatic test_random_reads();
        logic [31:0] ra, a; logic [1:0] s; logic [3:0] id; logic [2:0] sz; bit ok, src;
        for (int i = 0; i < 12; i++) begin
            src = 1'($urandom_range(0, 1));
            ra = 32'h1FC0_0000 + {$urandom_range(0, 7), 2'b00};
            s = 2'($urandom_range(0, 2));
            tick();
            if (src) begin
                data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = ra; data_sram_size = s;
            end else begin
                inst_sram_req = 1'b1; inst_sram_addr = ra; inst_sram_size = s;
            end
            #1;
            checks++; if ({data_sram_addrok, inst_sram_addrok} !== {src, ~src}) begin failures++; $display("FAIL rnd_addrok i=%0d got=%b exp=%b", i, {data_sram_addrok, inst_sram_addrok}, {src, ~src}); end
            tick(); data_sram_req = 1'b0; inst_sram_req = 1'b0;
            serve_read($urandom_range(0, 3), id, a, sz, ok);
            checks++; if ({ok, id, a, sz} !== {1'b1, (src ? 4'd1 : 4'd0), ra, 1'b0, s}) begin failures++; $display("FAIL rnd_ar i=%0d got=%h exp=%h", i, {ok, id, a, sz}, {1'b1, (src ? 4'd1 : 4'd0), ra, 1'b0, s}); end
            checks++; if ({data_sram_dataok, inst_sram_dataok, (src ? data_sram_rdata : inst_sram_rdata)} !== {src, ~src, mem_rd(ra)}) begin failures++; $display("FAIL rnd_resp i=%0d got=%h exp=%h", i, {data_sram_dataok, inst_sram_dataok, (src ? data_sram_rdata : inst_sram_rdata)}, {src, ~src, mem_rd(ra)}); end
        end
    endtask

    task automatic test_reset_mid();
        tick();
        inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC00100; inst_sram_size = 2'd2; #1;
        tick(); inst_sram_req = 1'b0;
        arready = 1'b1; tick(); arready = 1'b0;
        checks++; if (rready !== 1'b1) begin failures++; $display("FAIL rst_mid_in_r got=%b exp=1", rready); end
        #2 resetn = 1'b0; #1;
        checks++; if ({arvalid, rready, inst_sram_dataok, data_sram_dataok, inst_sram_rdata} !== 36'd0) begin failures++; $display("FAIL rst_mid_async got=%h exp=0", {arvalid, rready, inst_sram_dataok, data_sram_dataok, inst_sram_rdata}); end
        tick(); resetn = 1'b1;
        rvalid = 1'b1; rid = 4'd0; rdata = $urandom;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({inst_sram_dataok, data_sram_dataok, rready, arvalid} !== 4'b0) begin failures++; $display("FAIL rst_mid_no_resp cyc=%0d got=%b exp=0000", i, {inst_sram_dataok, data_sram_dataok, rready, arvalid}); end
        end
        rvalid = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd0; inst_sram_addr = 32'd0;
        inst_sram_wstrb = 4'd0; inst_sram_wdata = 32'd0;
        data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd0; data_sram_addr = 32'd0;
        data_sram_wstrb = 4'd0; data_sram_wdata = 32'd0;
        arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b1; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = 4'd0; bresp = 2'd0; bvalid = 1'b0;
        test_reset();
        test_inst_read();
        test_read_priority();
        test_write();
        test_write_blocks_read();
        test_ar_stall();
        test_random_reads();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
